// File: rtl/wr_burst_src.sv
`default_nettype none
// ============================================================================
// Module  : wr_burst_src
// Brief   : Write-side burst source for an async FIFO with read-pointer sync.
// Rev     : 1.0
// ============================================================================
module wr_burst_src #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          start,
  input  logic [AW:0]   burst_len,
  input  logic [DW-1:0] seed,
  input  logic          wfull,
  input  logic [AW:0]   rptr_gray,
  output logic          winc,
  output logic [DW-1:0] wdata,
  output logic [AW:0]   wq2_rptr,
  output logic [AW:0]   wlevel,
  output logic          busy,
  output logic          done,
  output logic [7:0]    stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [7:0]    c_STALL_MAX = 8'hFF;
  localparam logic [7:0]    c_STALL_ONE = 8'd1;
  localparam logic [DW-1:0] c_DATA_ONE  = DW'(1);
  localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW+1:0] c_REM_ONE   = (AW+2)'(1);
  localparam logic [AW+1:0] c_REM_MAX   = (AW+2)'(1) << (AW+1);

  state_t        r_state;
  logic          r_winc;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_wdata;
  logic [AW+1:0] r_remaining;
  logic [AW:0]   r_wcnt;
  logic [7:0]    r_stall;
  logic [AW:0]   r_sync1;
  logic [AW:0]   r_sync2;
  logic [AW:0]   w_rbin;
  logic [AW+1:0] w_len_load;

  // A zero length encodes the largest burst, one more than burst_len can hold.
  assign w_len_load = (burst_len == '0) ? c_REM_MAX : {1'b0, burst_len};

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state     <= IDLE;
      r_winc      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wdata     <= '0;
      r_remaining <= '0;
      r_wcnt      <= '0;
      r_stall     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= RUN;
            r_winc      <= 1'b1;
            r_busy      <= 1'b1;
            r_remaining <= w_len_load;
            r_wdata     <= seed;
            r_stall     <= '0;
          end
        end
        RUN: begin
          if (wfull) begin
            if (r_stall != c_STALL_MAX) begin
              r_stall <= r_stall + c_STALL_ONE;
            end
          end else begin
            r_wdata     <= r_wdata + c_DATA_ONE;
            r_remaining <= r_remaining - c_REM_ONE;
            r_wcnt      <= r_wcnt + c_CNT_ONE;
            if (r_remaining == c_REM_ONE) begin
              r_state <= FINISH;
              r_winc  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_winc  <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= rptr_gray;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i <= AW; i++) begin : g_gray2bin
    assign w_rbin[i] = ^r_sync2[AW:i];
  end

  assign winc      = r_winc;
  assign wdata     = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stall_cnt = r_stall;
  assign wq2_rptr  = r_sync2;
  assign wlevel    = r_wcnt - w_rbin;

endmodule
`default_nettype wire
